conv2d_layer_sequencer: RTL and testbench
=========================================

# conv2d_layer_sequencer

Controller that runs the `conv2d` engine once per layer over a list of up to `MAX_LAYERS` layers. Each layer has a host-programmed base-address descriptor. The block sits between the host/top level and one `conv2d` instance. It relocates the engine's four memory address streams (input, weight, bias, output) into a shared flat address space, pulses the engine's `start` for each layer, and waits for `done`. It also measures per-layer and total cycle counts, and aborts on a hung engine.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, width of all address ports and base registers
- `MAX_LAYERS`, 4, descriptor table depth
- `LAYER_W`, 2, layer index width (clog2 of `MAX_LAYERS`)
- `CYC_WIDTH`, 32, cycle counter width
- `TIMEOUT`, 65535, maximum RUN cycles per layer before abort

Ports:
- `clk`  in  1  sole clock; synchronous, active-high reset `rst`
- `rst`  in  1  synchronous active-high reset
- `cfg_we`  in  1  descriptor write strobe
- `cfg_layer`  in  `LAYER_W`  descriptor index
- `cfg_field`  in  2  field select: 0 input base, 1 weight base, 2 bias base, 3 output base
- `cfg_wdata`  in  `ADDR_WIDTH`  base value
- `start`  in  1  begin sequence
- `num_layers`  in  `LAYER_W`+1  layers to run; sampled with `start`
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle completion pulse
- `timeout_err`  out  1  sticky abort flag
- `cur_layer`  out  `LAYER_W`  index of the active layer
- `conv_start`  out  1  to `conv2d.start`
- `conv_done`  in  1  from `conv2d.done`
- `conv_input_addr`, `conv_weight_addr`, `conv_bias_addr`, `conv_output_addr`  in  `ADDR_WIDTH`  engine-side addresses
- `mem_input_addr`, `mem_weight_addr`, `mem_bias_addr`, `mem_output_addr`  out  `ADDR_WIDTH`  relocated addresses
- `layer_cycles`  out  `CYC_WIDTH`  cycle count of the last completed layer
- `layer_cycles_valid`  out  1  one-cycle pulse when `layer_cycles` updates
- `total_cycles`  out  `CYC_WIDTH`  sum over the sequence; final value is valid at `done`

## Operation
- FSM states:
  - IDLE → LAUNCH on `start` when `num_layers` is nonzero.
  - IDLE → FINISH on `start` when `num_layers` is 0.
  - LAUNCH → RUN.
  - RUN → NEXT on a `conv_done` rising edge (`conv_done & ~conv_done_q`).
  - RUN → FINISH on timeout.
  - NEXT → LAUNCH if `cur_layer+1 < num_eff`; otherwise NEXT → FINISH.
  - FINISH → IDLE.
- `num_eff = min(num_layers, MAX_LAYERS)`, latched at `start`.
- `conv_start` is 1 only in LAUNCH.
- The edge qualification means a `conv_done` held high from the previous layer never ends the next layer.
- Relocation is combinational: `mem_X_addr = conv_X_addr + base[cur_layer][X]`, truncated to `ADDR_WIDTH` (wraps modulo 2^`ADDR_WIDTH`).
- Per-layer counter:
  - Cleared to 1 in LAUNCH and incremented in each RUN cycle.
  - On the accepting edge, `layer_cycles` equals the number of cycles from LAUNCH through the accepting RUN cycle, inclusive.
  - `total_cycles` accumulates this value and is cleared on an accepted `start`.
  - Both counters saturate at all-ones.
- Timeout: the layer counter reaching `TIMEOUT+1` in RUN sets `timeout_err`, goes to FINISH, and produces no `layer_cycles_valid`. `timeout_err` clears on the next accepted `start`.
- Ignored inputs:
  - `start` is ignored while `busy`.
  - `cfg_we` is ignored while `busy`.
  - `cfg_layer >= MAX_LAYERS` is ignored.
  - `cfg_we` and `start` in the same IDLE cycle: the write takes effect first and the sequence uses the new value.

## Timing
- Reset values: state IDLE; all outputs 0; all base registers 0; `conv_done_q` 0.
- `start` sampled at edge E gives `conv_start` high in the cycle after E.
- `num_layers == 0` gives `done` high in the cycle after the start edge, with no `conv_start`.
- A `conv_done` edge sampled in RUN gives `layer_cycles_valid` in the NEXT cycle and `conv_start` for the next layer one cycle later (2-cycle inter-layer gap).
- `done` is high in the FINISH cycle; `busy` is high in that cycle and falls the following cycle.
- `rst` asserted in any state returns the block to reset values at the next edge and clears the descriptors.

## Structure
- Package `conv2d_seq_pkg` holds:
  - the state enum (IDLE, LAUNCH, RUN, NEXT, FINISH);
  - field codes `FLD_INPUT`, `FLD_WEIGHT`, `FLD_BIAS`, `FLD_OUTPUT`;
  - the default `TIMEOUT` constant.
- One sub-module, `conv2d_base_regfile`:
  - `MAX_LAYERS`×4 base registers with write port and reset;
  - exposes the four bases of `cur_layer`;
  - the four adders live in the top level.

## Test plan
- **Two-layer run.** Program bases:
  - layer 0: input 0x0000, weight 0x0040, bias 0x0060, output 0x0080;
  - layer 1: input 0x0100, weight 0x0140, bias 0x0160, output 0x0180.

  `num_layers=2`, with an engine model that asserts `done` 20 cycles after `start` and holds it. Expect two `conv_start` pulses 22 cycles apart, `layer_cycles=21` twice, `total_cycles=42`, one `done` pulse, and `timeout_err=0`.
- **Relocation and wrap.** In layer 1 with input base 0x0100, `conv_input_addr=0x0005` gives `mem_input_addr=0x0105`. With output base 0xFFFF, `conv_output_addr=0x0002` gives 0x0001.
- **Zero layers.** `start` with `num_layers=0` gives `done` in the next cycle, `conv_start` never asserted, and `total_cycles=0`.
- **Clamp.** `num_layers=7` with `MAX_LAYERS=4` gives exactly 4 `conv_start` pulses with `cur_layer` 0→3.
- **Timeout.** With `TIMEOUT=100` and `conv_done` held at 0, expect `timeout_err=1` and `done` 102 cycles after `conv_start`. A following `start` clears `timeout_err`.
- **Reset and ignored inputs.** Assert `rst` for one cycle mid-RUN: the next cycle shows `busy=0`, `conv_start=0`, all bases 0 and counters 0. Also check that `start` and `cfg_we` pulses during `busy` have no effect.

Source files
------------

// File: rtl/conv2d_seq_pkg.sv
// Shared types and constants for the conv2d layer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv2d_seq_pkg;

    // Sequencer states: IDLE waits for start, LAUNCH pulses the engine,
    // RUN waits for the engine, NEXT advances the layer, FINISH signals done.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

    // Descriptor field codes used by cfg_field
    localparam logic [1:0] FLD_INPUT  = 2'd0;
    localparam logic [1:0] FLD_WEIGHT = 2'd1;
    localparam logic [1:0] FLD_BIAS   = 2'd2;
    localparam logic [1:0] FLD_OUTPUT = 2'd3;

    // Default RUN-cycle budget per layer before the engine is declared hung
    localparam int DEFAULT_TIMEOUT = 65535;

endpackage

// File: rtl/conv2d_base_regfile.sv
// Per-layer base-address descriptor table (MAX_LAYERS x 4 bases).
// Latency: write visible the cycle after the write edge; read is combinational.
// Backpressure: none; out-of-range layer writes are dropped.
// Ports: clk/rst (sync active-high); we/wr_layer/wr_field/wdata write port;
//        rd_layer selects the layer whose four bases drive *_base outputs.
module conv2d_base_regfile
    import conv2d_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_LAYERS = 4,
    parameter int LAYER_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [LAYER_W-1:0]    wr_layer,
    input  logic [1:0]            wr_field,
    input  logic [ADDR_WIDTH-1:0] wdata,
    input  logic [LAYER_W-1:0]    rd_layer,
    output logic [ADDR_WIDTH-1:0] input_base,
    output logic [ADDR_WIDTH-1:0] weight_base,
    output logic [ADDR_WIDTH-1:0] bias_base,
    output logic [ADDR_WIDTH-1:0] output_base
);

    logic [ADDR_WIDTH-1:0] bases [MAX_LAYERS][4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < MAX_LAYERS; l++) begin
                for (int f = 0; f < 4; f++) begin
                    bases[l][f] <= '0;
                end
            end
        end else if (we && (int'(wr_layer) < MAX_LAYERS)) begin
            bases[wr_layer][wr_field] <= wdata;
        end
    end

    assign input_base  = bases[rd_layer][FLD_INPUT];
    assign weight_base = bases[rd_layer][FLD_WEIGHT];
    assign bias_base   = bases[rd_layer][FLD_BIAS];
    assign output_base = bases[rd_layer][FLD_OUTPUT];

endmodule

// File: rtl/conv2d_layer_sequencer.sv
// Runs a conv2d engine once per layer, relocating its four address streams
// by per-layer bases and measuring per-layer / total cycle counts.
// Latency: conv_start one cycle after an accepted start; 2-cycle gap between
//          a conv_done edge and the next layer's conv_start.
// Backpressure: start and cfg_we are ignored while busy; a hung engine is
//               aborted after TIMEOUT RUN cycles with sticky timeout_err.
// Ports: cfg_* descriptor write; start/num_layers launch; busy/done/
//        timeout_err/cur_layer status; conv_* engine side; mem_* relocated
//        addresses; layer_cycles(_valid)/total_cycles performance counters.
module conv2d_layer_sequencer
    import conv2d_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_LAYERS = 4,
    parameter int LAYER_W    = 2,
    parameter int CYC_WIDTH  = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [LAYER_W-1:0]    cfg_layer,
    input  logic [1:0]            cfg_field,
    input  logic [ADDR_WIDTH-1:0] cfg_wdata,
    input  logic                  start,
    input  logic [LAYER_W:0]      num_layers,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [LAYER_W-1:0]    cur_layer,
    output logic                  conv_start,
    input  logic                  conv_done,
    input  logic [ADDR_WIDTH-1:0] conv_input_addr,
    input  logic [ADDR_WIDTH-1:0] conv_weight_addr,
    input  logic [ADDR_WIDTH-1:0] conv_bias_addr,
    input  logic [ADDR_WIDTH-1:0] conv_output_addr,
    output logic [ADDR_WIDTH-1:0] mem_input_addr,
    output logic [ADDR_WIDTH-1:0] mem_weight_addr,
    output logic [ADDR_WIDTH-1:0] mem_bias_addr,
    output logic [ADDR_WIDTH-1:0] mem_output_addr,
    output logic [CYC_WIDTH-1:0]  layer_cycles,
    output logic                  layer_cycles_valid,
    output logic [CYC_WIDTH-1:0]  total_cycles
);

    localparam logic [CYC_WIDTH-1:0] CYC_MAX  = '1;
    localparam logic [CYC_WIDTH-1:0] TO_LIMIT = CYC_WIDTH'(TIMEOUT) + CYC_WIDTH'(1);
    localparam logic [LAYER_W:0]     MAX_EFF  = (LAYER_W + 1)'(MAX_LAYERS);

    seq_state_t            state;
    logic                  conv_done_q;
    logic [LAYER_W:0]      num_eff;
    logic [CYC_WIDTH-1:0]  layer_cnt;

    logic                  cfg_accept;
    logic                  done_edge;
    logic [CYC_WIDTH-1:0]  layer_cnt_inc;
    logic [CYC_WIDTH:0]    total_sum;
    logic [CYC_WIDTH-1:0]  total_next;
    logic [LAYER_W:0]      next_layer;
    logic [LAYER_W:0]      num_clamped;

    logic [ADDR_WIDTH-1:0] input_base;
    logic [ADDR_WIDTH-1:0] weight_base;
    logic [ADDR_WIDTH-1:0] bias_base;
    logic [ADDR_WIDTH-1:0] output_base;

    // Descriptors may only change while no sequence is using them
    assign cfg_accept = cfg_we && (state == ST_IDLE);

    // Only a rising edge ends a layer, so a done level left over from the
    // previous layer cannot terminate the next one early.
    assign done_edge = conv_done && !conv_done_q;

    // Saturating counter arithmetic
    assign layer_cnt_inc = (layer_cnt == CYC_MAX) ? layer_cnt : layer_cnt + CYC_WIDTH'(1);
    assign total_sum     = {1'b0, total_cycles} + {1'b0, layer_cnt_inc};
    assign total_next    = total_sum[CYC_WIDTH] ? CYC_MAX : total_sum[CYC_WIDTH-1:0];

    assign next_layer  = {1'b0, cur_layer} + (LAYER_W + 1)'(1);
    assign num_clamped = (num_layers > MAX_EFF) ? MAX_EFF : num_layers;

    conv2d_base_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_LAYERS (MAX_LAYERS),
        .LAYER_W    (LAYER_W)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .we          (cfg_accept),
        .wr_layer    (cfg_layer),
        .wr_field    (cfg_field),
        .wdata       (cfg_wdata),
        .rd_layer    (cur_layer),
        .input_base  (input_base),
        .weight_base (weight_base),
        .bias_base   (bias_base),
        .output_base (output_base)
    );

    // Relocation wraps modulo 2^ADDR_WIDTH
    assign mem_input_addr  = conv_input_addr  + input_base;
    assign mem_weight_addr = conv_weight_addr + weight_base;
    assign mem_bias_addr   = conv_bias_addr   + bias_base;
    assign mem_output_addr = conv_output_addr + output_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            conv_done_q        <= 1'b0;
            num_eff            <= '0;
            layer_cnt          <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            timeout_err        <= 1'b0;
            cur_layer          <= '0;
            conv_start         <= 1'b0;
            layer_cycles       <= '0;
            layer_cycles_valid <= 1'b0;
            total_cycles       <= '0;
        end else begin
            conv_done_q        <= conv_done;
            conv_start         <= 1'b0;
            done               <= 1'b0;
            layer_cycles_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        timeout_err  <= 1'b0;
                        total_cycles <= '0;
                        cur_layer    <= '0;
                        num_eff      <= num_clamped;
                        busy         <= 1'b1;
                        if (num_layers == '0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_LAUNCH;
                            conv_start <= 1'b1;
                        end
                    end
                end

                ST_LAUNCH: begin
                    // The LAUNCH cycle itself counts as the first layer cycle
                    layer_cnt <= CYC_WIDTH'(1);
                    state     <= ST_RUN;
                end

                ST_RUN: begin
                    layer_cnt <= layer_cnt_inc;
                    if (done_edge) begin
                        layer_cycles       <= layer_cnt_inc;
                        layer_cycles_valid <= 1'b1;
                        total_cycles       <= total_next;
                        state              <= ST_NEXT;
                    end else if (layer_cnt >= TO_LIMIT) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= ST_FINISH;
                    end
                end

                ST_NEXT: begin
                    if (next_layer < num_eff) begin
                        cur_layer  <= next_layer[LAYER_W-1:0];
                        conv_start <= 1'b1;
                        state      <= ST_LAUNCH;
                    end else begin
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_layer_sequencer.sv
// Testbench for conv2d_layer_sequencer: engine model plus timing reference
// computed from layer count, engine latency and timeout budget.
// Latency/backpressure: n/a.
module tb_conv2d_layer_sequencer;
    import conv2d_seq_pkg::*;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_layer;
    logic [1:0]  cfg_field;
    logic [15:0] cfg_wdata;
    logic        start;
    logic [2:0]  num_layers;
    logic        busy, done, timeout_err, conv_start, conv_done;
    logic [1:0]  cur_layer;
    logic [15:0] conv_input_addr, conv_weight_addr, conv_bias_addr, conv_output_addr;
    logic [15:0] mem_input_addr, mem_weight_addr, mem_bias_addr, mem_output_addr;
    logic [31:0] layer_cycles, total_cycles;
    logic        layer_cycles_valid;

    conv2d_layer_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .start(start),
        .num_layers(num_layers), .busy(busy), .done(done),
        .timeout_err(timeout_err), .cur_layer(cur_layer),
        .conv_start(conv_start), .conv_done(conv_done),
        .conv_input_addr(conv_input_addr), .conv_weight_addr(conv_weight_addr),
        .conv_bias_addr(conv_bias_addr), .conv_output_addr(conv_output_addr),
        .mem_input_addr(mem_input_addr), .mem_weight_addr(mem_weight_addr),
        .mem_bias_addr(mem_bias_addr), .mem_output_addr(mem_output_addr),
        .layer_cycles(layer_cycles), .layer_cycles_valid(layer_cycles_valid),
        .total_cycles(total_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: done rises eng_delay cycles after the start pulse and
    // stays high; a done level present at start lingers for eng_hold cycles.
    int eng_delay = 0;
    int eng_hold = 0;
    int eng_cnt = 0;
    bit eng_on = 0;
    bit eng_stale = 0;
    always @(posedge clk) begin
        if (rst) begin
            eng_on <= 0; eng_cnt <= 0; eng_stale <= 0;
        end else if (conv_start) begin
            eng_on <= 1; eng_cnt <= 1; eng_stale <= conv_done;
        end else if (eng_on && eng_cnt < 100000) begin
            eng_cnt <= eng_cnt + 1;
        end
    end
    assign conv_done = eng_on && ((eng_delay != 0 && eng_cnt >= eng_delay) ||
                                  (eng_stale && eng_cnt <= eng_hold));

    // Reference base table: updated only when a write is known to be accepted
    logic [15:0] mbase [4][4];

    // Observation queues filled by the monitor
    int q_start[$];
    int q_layer[$];
    int q_to_launch[$];
    int q_lc[$];
    int q_done[$];
    longint tot_at_done;
    int to_at_done;
    int busy_cnt;
    bit mon_en = 0;

    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (conv_start) begin
                q_start.push_back(cyc);
                q_layer.push_back(int'(cur_layer));
                q_to_launch.push_back(int'(timeout_err));
            end
            if (layer_cycles_valid) q_lc.push_back(int'(layer_cycles));
            if (done) begin
                q_done.push_back(cyc);
                tot_at_done = longint'(total_cycles);
                to_at_done = int'(timeout_err);
            end
            if (busy) busy_cnt++;
            check("reloc_input",  mem_input_addr,  add16(conv_input_addr,  mbase[cur_layer][0]));
            check("reloc_weight", mem_weight_addr, add16(conv_weight_addr, mbase[cur_layer][1]));
            check("reloc_bias",   mem_bias_addr,   add16(conv_bias_addr,   mbase[cur_layer][2]));
            check("reloc_output", mem_output_addr, add16(conv_output_addr, mbase[cur_layer][3]));
        end
    end

    task automatic clear_obs();
        q_start.delete(); q_layer.delete(); q_to_launch.delete();
        q_lc.delete(); q_done.delete();
        tot_at_done = -1; to_at_done = -1; busy_cnt = 0;
    endtask

    task automatic cfg_write(input logic [1:0] lay, input logic [1:0] fld, input logic [15:0] val);
        @(negedge clk);
        cfg_we = 1; cfg_layer = lay; cfg_field = fld; cfg_wdata = val;
        @(negedge clk);
        cfg_we = 0;
        mbase[lay][fld] = val;
    endtask

    // Runs one sequence and checks it against the timing reference.
    // d == 0 means the engine never finishes.
    task automatic run_seq(input int n, input int d, input int hold,
                           input bit poke, input bit reloc, input bit same_wr);
        int s, neff, exp_starts, exp_done, nlc, exp_to;
        longint exp_total;
        bit done_seen, reloc_done;
        logic [15:0] wv;
        @(negedge clk);
        clear_obs();
        eng_delay = d; eng_hold = hold;
        start = 1; num_layers = 3'(n);
        wv = 16'($urandom);
        if (same_wr) begin
            cfg_we = 1; cfg_layer = 2'd0; cfg_field = FLD_INPUT; cfg_wdata = wv;
        end
        s = cyc;
        @(negedge clk);
        start = 0; cfg_we = 0;
        if (same_wr) mbase[0][0] = wv;
        done_seen = 0; reloc_done = 0;
        for (int k = 0; k < 3000; k++) begin
            #3;
            if (q_done.size() != 0) begin done_seen = 1; break; end
            if (reloc && !reloc_done && q_start.size() == 2) begin
                conv_input_addr = 16'h0005; conv_output_addr = 16'h0002;
                #1;
                check("reloc_layer", cur_layer, 2'd1);
                check("reloc_in_0105", mem_input_addr, 16'h0105);
                check("reloc_out_wrap", mem_output_addr, 16'h0001);
                reloc_done = 1;
            end else begin
                conv_input_addr = 16'($urandom); conv_weight_addr = 16'($urandom);
                conv_bias_addr = 16'($urandom); conv_output_addr = 16'($urandom);
            end
            if (poke && k == 10) begin
                start = 1; num_layers = 3'd1;
                cfg_we = 1; cfg_layer = 2'($urandom_range(0, 3));
                cfg_field = 2'($urandom_range(0, 3)); cfg_wdata = 16'($urandom);
            end else if (poke && k == 11) begin
                start = 0; cfg_we = 0;
            end
            @(negedge clk);
        end
        start = 0; cfg_we = 0;
        check("done_seen", done_seen, 1);
        if (reloc) check("reloc_reached", reloc_done, 1);

        neff = (n > 4) ? 4 : n;
        if (neff == 0) begin
            exp_starts = 0; exp_done = s + 1; exp_total = 0; exp_to = 0; nlc = 0;
        end else if (d == 0 || d > TO + 1) begin
            exp_starts = 1; exp_done = s + 1 + TO + 2; exp_total = 0; exp_to = 1; nlc = 0;
        end else begin
            exp_starts = neff; exp_done = s + 1 + neff * (d + 2);
            exp_total = longint'(neff * (d + 1)); exp_to = 0; nlc = neff;
        end

        check("start_count", q_start.size(), exp_starts);
        for (int i = 0; i < q_start.size() && i < exp_starts; i++) begin
            check("start_cycle", q_start[i] - s, 1 + i * (d + 2));
            check("start_layer", q_layer[i], i);
        end
        if (q_to_launch.size() != 0) check("to_clear_at_start", q_to_launch[0], 0);
        check("lc_count", q_lc.size(), nlc);
        for (int i = 0; i < q_lc.size() && i < nlc; i++) check("lc_value", q_lc[i], d + 1);
        check("done_count", q_done.size(), 1);
        if (q_done.size() != 0) check("done_cycle", q_done[0] - s, exp_done - s);
        check("total_at_done", tot_at_done, exp_total);
        check("timeout_at_done", to_at_done, exp_to);
        check("busy_cycles", busy_cnt, exp_done - s);
        @(negedge clk);
        #3;
        check("busy_after", busy, 1'b0);
        check("done_after", done, 1'b0);
    endtask

    initial begin
        rst = 1; cfg_we = 0; cfg_layer = 0; cfg_field = 0; cfg_wdata = 0;
        start = 0; num_layers = 0;
        conv_input_addr = 0; conv_weight_addr = 0; conv_bias_addr = 0; conv_output_addr = 0;
        for (int l = 0; l < 4; l++) for (int f = 0; f < 4; f++) mbase[l][f] = 16'h0;
        clear_obs();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_conv_start", conv_start, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_cur_layer", cur_layer, 2'd0);
        check("rst_layer_cycles", layer_cycles, 32'd0);
        check("rst_total", total_cycles, 32'd0);
        check("rst_lc_valid", layer_cycles_valid, 1'b0);
        rst = 0;
        mon_en = 1;

        // Two-layer run with the reference bases; busy-time pokes must be ignored
        cfg_write(2'd0, FLD_INPUT, 16'h0000); cfg_write(2'd0, FLD_WEIGHT, 16'h0040);
        cfg_write(2'd0, FLD_BIAS,  16'h0060); cfg_write(2'd0, FLD_OUTPUT, 16'h0080);
        cfg_write(2'd1, FLD_INPUT, 16'h0100); cfg_write(2'd1, FLD_WEIGHT, 16'h0140);
        cfg_write(2'd1, FLD_BIAS,  16'h0160); cfg_write(2'd1, FLD_OUTPUT, 16'h0180);
        run_seq(2, 20, 1, 1'b1, 1'b0, 1'b0);

        // Relocation with wrap on the output stream
        cfg_write(2'd1, FLD_OUTPUT, 16'hFFFF);
        run_seq(2, 30, 0, 1'b0, 1'b1, 1'b0);

        // Zero layers, clamp, timeout, then a start that must clear the error
        run_seq(0, 10, 0, 1'b0, 1'b0, 1'b0);
        run_seq(7, 15, 2, 1'b1, 1'b0, 1'b0);
        run_seq(2, 0, 0, 1'b0, 1'b0, 1'b0);
        run_seq(1, 12, 0, 1'b0, 1'b0, 1'b1);

        // Randomized sequences
        for (int it = 0; it < 6; it++) begin
            int n, h, d;
            for (int w = 0; w < 3; w++)
                cfg_write(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
            n = $urandom_range(0, 7);
            h = $urandom_range(0, 3);
            d = $urandom_range(h + 2, 40);
            run_seq(n, d, h, (n != 0 && d >= 15), 1'b0, 1'b0);
        end

        // Reset in the middle of layer 1
        clear_obs();
        eng_delay = 10; eng_hold = 0;
        @(negedge clk);
        num_layers = 3'd3; start = 1;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        #3;
        check("pre_rst_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int l = 0; l < 4; l++) for (int f = 0; f < 4; f++) mbase[l][f] = 16'h0;
        conv_input_addr = 16'h1234; conv_output_addr = 16'hBEEF;
        #3;
        check("mrst_busy", busy, 1'b0);
        check("mrst_conv_start", conv_start, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_cur_layer", cur_layer, 2'd0);
        check("mrst_layer_cycles", layer_cycles, 32'd0);
        check("mrst_total", total_cycles, 32'd0);
        check("mrst_timeout", timeout_err, 1'b0);
        check("mrst_in_base0", mem_input_addr, 16'h1234);
        check("mrst_out_base0", mem_output_addr, 16'hBEEF);

        // All four layers must now relocate with zero bases
        run_seq(4, 10, 0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
